activation_skew_feeder: RTL
===========================

// Module: activation_skew_feeder
// PURPOSE
//  Read controller and diagonal-skew stage between the activation memory and the systolic array.
//  On start, reads SIZE activation rows (one SIZE-lane word per read, 1-cycle read latency).
//  Delays lane k by k cycles so activations enter the array as a wavefront.
//  Zeroes lanes that carry no valid data.
// PARAMETERS
//  SIZE        8                 array dimension: lanes per word and words per tile
//  ACT_W       7                 bits per activation lane
//  ADDR_W      $clog2(SIZE)      read-address width
// PORTS
//  clk            in   1           clock, all logic on posedge
//  rst_n          in   1           synchronous active-low reset
//  start          in   1           1-cycle request to stream one tile; sampled only in IDLE
//  Rd_en          out  1           read enable to activation memory
//  Rd_Addr        out  ADDR_W      read address (column index 0..SIZE-1)
//  Activation_in  in   SIZE*ACT_W  read data, valid the cycle after Rd_en; lane k = [k*ACT_W +: ACT_W]
//  Act_out        out  SIZE*ACT_W  skewed activations to array; lane k = [k*ACT_W +: ACT_W]
//  Act_valid      out  SIZE        per-lane valid for Act_out
//  busy           out  1           high from the cycle after start is accepted until done
//  done           out  1           1-cycle pulse after the last lane's last word is presented
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; Rd_en=0, Rd_Addr=0, busy=0, done=0, Act_valid=0, Act_out=0.
//    All skew registers are cleared. Reset mid-tile aborts the tile; no done pulse is issued.
//  - Fixed to one clock; no other synchronous or asynchronous clears.
//  - FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
//    - IDLE: start=1 at cycle T -> READ at T+1.
//    - READ: Rd_en=1 for exactly SIZE cycles (T+1..T+SIZE), Rd_Addr = 0,1,...,SIZE-1. Then -> DRAIN.
//    - DRAIN: Rd_en=0, Rd_Addr held 0. Stays here until all skew pipelines are empty.
//    - DONE: done=1 for one cycle, busy=0 in that cycle, then -> IDLE.
//  - Capture: a tag bit travels with each read. Activation_in is registered at T+2+j for address j,
//    together with its valid flag.
//  - Skew: lane k passes through k further register stages.
//    - Lane k, word j appears on Act_out at cycle T+3+j+k with Act_valid[k]=1.
//    - For SIZE=8: first output at T+3 (lane 0, j=0); last at T+17 (lane 7, j=7); done at T+18.
//  - Act_out lane k is forced to 0 whenever Act_valid[k]=0, so the array never sees stale data.
//  - busy = 1 in READ and DRAIN.
//  - start while not IDLE is ignored; it is not queued.
//  - start in the DONE cycle is ignored. start in the cycle after done is accepted.
//  - Back-to-back tiles: minimum spacing start-to-start = 2*SIZE+3 cycles.
//  - Activation values are passed through unmodified (no sign/width change); lanes are independent.
//  - System rule: the activation loader must not write activation memory while busy=1,
//    because writes pre-empt reads.
//  - Rd_Addr wrap: the counter stops at SIZE-1; it never wraps within a tile.
// TESTING
//  1. Reset then idle 10 cycles, no start -> Rd_en=0, busy=0, done=0, Act_valid=0, Act_out=0 throughout.
//  2. SIZE=8, start at T=0, memory model returns lane k of word j = 8*j+k
//     -> Rd_Addr 0..7 on cycles 1..8.
//     -> Act_out lane k = 8*j+k exactly at cycle 3+j+k.
//     -> done pulse at cycle 18 only.
//  3. Pulse start again at cycles 4 and 18 -> both ignored; a single Rd_en burst; one done.
//  4. Drive rst_n=0 at cycle 6 of a tile
//     -> next cycle all outputs 0, state IDLE, no done.
//     -> start at cycle 8 runs a full clean tile.
//  5. Back-to-back: start at 0 and at 19
//     -> second Rd_en burst on 20..27, no lane overlap, two done pulses (18, 37).
//  6. Data with top bit set (7'h7F) and 7'h40 in alternate lanes
//     -> values are delivered bit-exact; invalid cycles read 0.

Source files
------------

// File: rtl/activation_skew_feeder_if.sv
// Bundle between the activation memory, the tile sequencer and the array.
// master: sequencer/memory side (start, read data); slave: the feeder.
interface activation_skew_feeder_if #(
    parameter int SIZE   = 8,
    parameter int ACT_W  = 7,
    parameter int ADDR_W = $clog2(SIZE)
);
    logic                  start;
    logic                  Rd_en;
    logic [ADDR_W-1:0]     Rd_Addr;
    logic [SIZE*ACT_W-1:0] Activation_in;
    logic [SIZE*ACT_W-1:0] Act_out;
    logic [SIZE-1:0]       Act_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output start,
        output Activation_in,
        input  Rd_en,
        input  Rd_Addr,
        input  Act_out,
        input  Act_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  Activation_in,
        output Rd_en,
        output Rd_Addr,
        output Act_out,
        output Act_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/activation_skew_feeder.sv
// Reads one SIZE x SIZE activation tile and skews lane k by k cycles.
// Ports: clk, rst_n (sync, active low), bus (slave: start/read port/array side).
module activation_skew_feeder #(
    parameter int SIZE   = 8,
    parameter int ACT_W  = 7,
    parameter int ADDR_W = $clog2(SIZE)
) (
    input logic clk,
    input logic rst_n,
    activation_skew_feeder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic              rd_tag;

    logic [ACT_W-1:0]  lane_o [SIZE];
    logic              lane_v [SIZE];
    logic              lane_p [SIZE];
    logic              pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            rd_tag <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            // tag lines up with the read data one cycle later
            rd_tag <= (state == READ);
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nxt = READ;
            end
            READ: begin
                if (addr == ADDR_W'(SIZE - 1)) begin
                    state_nxt = DRAIN;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // nothing in flight except the word on the outputs now
                if (!rd_tag && !pend) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar k = 0; k < SIZE; k++) begin : g_lane
        logic [ACT_W-1:0] d [0:k];
        logic [ACT_W-1:0] din;

        assign din = rd_tag ? bus.Activation_in[k*ACT_W +: ACT_W] : '0;

        if (k == 0) begin : g_head
            logic v;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v    <= 1'b0;
                    d[0] <= '0;
                end else begin
                    v    <= rd_tag;
                    d[0] <= din;
                end
            end
            assign lane_v[k] = v;
            assign lane_p[k] = 1'b0;
        end else begin : g_tail
            logic [k:0] v;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v <= '0;
                    for (int i = 0; i <= k; i++) d[i] <= '0;
                end else begin
                    v    <= {v[k-1:0], rd_tag};
                    d[0] <= din;
                    for (int i = k; i > 0; i--) d[i] <= d[i-1];
                end
            end
            assign lane_v[k] = v[k];
            assign lane_p[k] = |v[k-1:0];
        end

        assign lane_o[k] = lane_v[k] ? d[k] : '0;
    end

    always_comb begin
        bus.Act_out   = '0;
        bus.Act_valid = '0;
        pend          = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            bus.Act_out[k*ACT_W +: ACT_W] = lane_o[k];
            bus.Act_valid[k]              = lane_v[k];
            pend                          = pend | lane_p[k];
        end
    end

    assign bus.Rd_en   = (state == READ);
    assign bus.Rd_Addr = addr;
    assign bus.busy    = (state == READ) || (state == DRAIN);
    assign bus.done    = (state == DONE);
endmodule
